// File: rtl/arbiter_pkg.sv
// Shared types and constants for the stb/ack stream arbiter family.
// The state encodings are plain logic constants so older code can still compare against them.
package arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_OUTPUT = 2'd2
   } arb_state_e;

   localparam logic [1:0] ST_IDLE   = S_IDLE;
   localparam logic [1:0] ST_ACCEPT = S_ACCEPT;
   localparam logic [1:0] ST_OUTPUT = S_OUTPUT;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // A single channel still needs a one-bit index field.
   function automatic int id_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational requester picker: lowest set index overall (fixed priority), or the lowest
// set index at/above pointer, falling back to the lowest overall when nothing lies above it.
module rr_priority_select
   import arbiter_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int IDW      = 2
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [IDW-1:0]      pointer,
   input  logic                mode,
   output logic [IDW-1:0]      grant,
   output logic                valid
);

   logic [IDW-1:0] w_lo_grant;
   logic [IDW-1:0] w_hi_grant;
   logic           w_hi_found;

   // Scanning downward and overwriting leaves the lowest qualifying index.
   always_comb begin
      w_lo_grant = '0;
      w_hi_grant = '0;
      w_hi_found = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_lo_grant = IDW'(i);
            if (i >= int'(pointer)) begin
               w_hi_grant = IDW'(i);
               w_hi_found = 1'b1;
            end
         end
      end
   end

   assign valid = |req;
   assign grant = (mode && w_hi_found) ? w_hi_grant : w_lo_grant;

endmodule

// File: rtl/rr_arbiter_n.sv
// N-channel stb/ack stream arbiter: grants one input word at a time to a single output stream
// and tags each forwarded word with the index of the channel it came from.
module rr_arbiter_n
   import arbiter_pkg::*;
#(
   parameter int  CHANNELS = 4,
   parameter int  WIDTH    = 16,
   parameter int  MODE     = MODE_RR,
   localparam int IDW      = id_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] input_data,
   input  logic [CHANNELS-1:0]       input_stb,
   output logic [CHANNELS-1:0]       input_ack,
   output logic [WIDTH-1:0]          output_z,
   output logic [IDW-1:0]            output_z_id,
   output logic                      output_z_stb,
   input  logic                      output_z_ack,
   output logic [1:0]                o_dbg_state,
   output logic [IDW-1:0]            o_dbg_pointer
);

   // Handshake: a word moves on a rising edge where its stb and ack are both high; the
   // sender keeps stb and data steady until then, and output_z_stb holds until output_z_ack.

   logic [1:0]          r_state;
   logic [IDW-1:0]      r_sel;
   logic [IDW-1:0]      r_ptr;
   logic [CHANNELS-1:0] r_ack;
   logic [WIDTH-1:0]    r_z;
   logic [IDW-1:0]      r_z_id;
   logic                r_z_stb;

   logic [IDW-1:0]      w_grant;
   logic                w_valid;
   logic [CHANNELS-1:0] w_grant_onehot;
   logic                w_sel_stb;
   logic                w_sel_ack;
   logic [WIDTH-1:0]    w_sel_data;
   logic [IDW-1:0]      w_next_ptr;

   rr_priority_select #(
      .CHANNELS (CHANNELS),
      .IDW      (IDW)
   ) u_select (
      .req     (input_stb),
      .pointer (r_ptr),
      .mode    (MODE == MODE_RR),
      .grant   (w_grant),
      .valid   (w_valid)
   );

   // Compare-based muxing keeps every index in range, including the single-channel build.
   always_comb begin
      w_grant_onehot = '0;
      w_sel_stb      = 1'b0;
      w_sel_ack      = 1'b0;
      w_sel_data     = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_grant_onehot[c] = (w_grant == IDW'(c));
         if (r_sel == IDW'(c)) begin
            w_sel_stb  = input_stb[c];
            w_sel_ack  = r_ack[c];
            w_sel_data = input_data[c*WIDTH +: WIDTH];
         end
      end
   end

   assign w_next_ptr = (r_sel == IDW'(CHANNELS - 1)) ? '0 : r_sel + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_ptr   <= '0;
         r_ack   <= '0;
         r_z     <= '0;
         r_z_id  <= '0;
         r_z_stb <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_sel   <= w_grant;
                  r_ack   <= w_grant_onehot;
                  r_state <= ST_ACCEPT;
               end
            end
            ST_ACCEPT: begin
               // A granted producer that drops stb is simply waited on.
               if (w_sel_stb && w_sel_ack) begin
                  r_z     <= w_sel_data;
                  r_z_id  <= r_sel;
                  r_ack   <= '0;
                  r_z_stb <= 1'b1;
                  r_ptr   <= w_next_ptr;
                  r_state <= ST_OUTPUT;
               end
            end
            ST_OUTPUT: begin
               if (r_z_stb && output_z_ack) begin
                  r_z_stb <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_ack   <= '0;
               r_z_stb <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign input_ack     = r_ack;
   assign output_z      = r_z;
   assign output_z_id   = r_z_id;
   assign output_z_stb  = r_z_stb;
   assign o_dbg_state   = r_state;
   assign o_dbg_pointer = r_ptr;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: a cycle table for the basic and round-robin flows, then
// hand-written sequences for stalls, reset mid-transfer, pointer wrap, fixed priority and one channel.
module tb_rr_arbiter_n;
   import arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Round-robin, 4 channels
   logic [63:0] rr_data = '0;
   logic [3:0]  rr_stb = '0;
   logic [3:0]  rr_ack;
   logic [15:0] rr_z;
   logic [1:0]  rr_id;
   logic        rr_z_stb;
   logic        rr_z_ack = 1'b0;
   logic [1:0]  rr_dbg_state;
   logic [1:0]  rr_dbg_ptr;

   // Fixed priority, 4 channels
   logic [63:0] fp_data = '0;
   logic [3:0]  fp_stb = '0;
   logic [3:0]  fp_ack;
   logic [15:0] fp_z;
   logic [1:0]  fp_id;
   logic        fp_z_stb;
   logic        fp_z_ack = 1'b0;
   logic [1:0]  fp_dbg_state;
   logic [1:0]  fp_dbg_ptr;

   // Round-robin, single channel
   logic [15:0] one_data = '0;
   logic [0:0]  one_stb = '0;
   logic [0:0]  one_ack;
   logic [15:0] one_z;
   logic [0:0]  one_id;
   logic        one_z_stb;
   logic        one_z_ack = 1'b0;
   logic [1:0]  one_dbg_state;
   logic [0:0]  one_dbg_ptr;

   rr_arbiter_n #(.CHANNELS(4), .WIDTH(16), .MODE(MODE_RR)) u_rr (
      .clk(clk), .rst(rst), .input_data(rr_data), .input_stb(rr_stb), .input_ack(rr_ack),
      .output_z(rr_z), .output_z_id(rr_id), .output_z_stb(rr_z_stb), .output_z_ack(rr_z_ack),
      .o_dbg_state(rr_dbg_state), .o_dbg_pointer(rr_dbg_ptr)
   );

   rr_arbiter_n #(.CHANNELS(4), .WIDTH(16), .MODE(MODE_FIXED)) u_fp (
      .clk(clk), .rst(rst), .input_data(fp_data), .input_stb(fp_stb), .input_ack(fp_ack),
      .output_z(fp_z), .output_z_id(fp_id), .output_z_stb(fp_z_stb), .output_z_ack(fp_z_ack),
      .o_dbg_state(fp_dbg_state), .o_dbg_pointer(fp_dbg_ptr)
   );

   rr_arbiter_n #(.CHANNELS(1), .WIDTH(16), .MODE(MODE_RR)) u_one (
      .clk(clk), .rst(rst), .input_data(one_data), .input_stb(one_stb), .input_ack(one_ack),
      .output_z(one_z), .output_z_id(one_id), .output_z_stb(one_z_stb), .output_z_ack(one_z_ack),
      .o_dbg_state(one_dbg_state), .o_dbg_pointer(one_dbg_ptr)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic [63:0] data;
      logic [3:0]  stb;
      logic        z_ack;
      logic [3:0]  exp_ack;
      logic        exp_z_stb;
      logic [15:0] exp_z;
      logic [1:0]  exp_id;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [63:0] d, input logic [3:0] s,
                               input logic za, input logic [3:0] ea, input logic es,
                               input logic [15:0] ez, input logic [1:0] ei);
      vec_t v;
      v.rst = r; v.data = d; v.stb = s; v.z_ack = za;
      v.exp_ack = ea; v.exp_z_stb = es; v.exp_z = ez; v.exp_id = ei;
      return v;
   endfunction

   initial begin
      logic [63:0] d1;
      logic [63:0] d2;
      int          cnt;

      // Table: each row's inputs are applied before an edge, expectations sampled after it.
      d1 = 64'h0000_BEEF_0000_0000;
      d2 = 64'h3333_2222_1111_0000;
      vecs.push_back(mk(1'b1, d1, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0));
      vecs.push_back(mk(1'b0, d1, 4'b0100, 1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0));
      vecs.push_back(mk(1'b0, d1, 4'b0100, 1'b1, 4'b0000, 1'b1, 16'hBEEF, 2'd2));
      vecs.push_back(mk(1'b0, d1, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'hBEEF, 2'd2));
      vecs.push_back(mk(1'b0, d1, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'hBEEF, 2'd2));
      vecs.push_back(mk(1'b1, d2, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0));
      for (int w = 0; w < 5; w++) begin
         int ch;
         int pch;
         ch  = w % 4;
         pch = (w == 0) ? 0 : (w - 1) % 4;
         vecs.push_back(mk(1'b0, d2, 4'hF, 1'b1, 4'(1 << ch), 1'b0, 16'(pch * 'h1111), 2'(pch)));
         vecs.push_back(mk(1'b0, d2, 4'hF, 1'b1, 4'b0000, 1'b1, 16'(ch * 'h1111), 2'(ch)));
         vecs.push_back(mk(1'b0, d2, 4'hF, 1'b1, 4'b0000, 1'b0, 16'(ch * 'h1111), 2'(ch)));
      end
      vecs.push_back(mk(1'b0, d2, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         rst      = vecs[i].rst;
         rr_data  = vecs[i].data;
         rr_stb   = vecs[i].stb;
         rr_z_ack = vecs[i].z_ack;
         step();
         chk($sformatf("vec%0d ack", i), rr_ack, vecs[i].exp_ack);
         chk($sformatf("vec%0d z_stb", i), rr_z_stb, vecs[i].exp_z_stb);
         chk($sformatf("vec%0d z", i), rr_z, vecs[i].exp_z);
         chk($sformatf("vec%0d id", i), rr_id, vecs[i].exp_id);
      end
      rst = 1'b0;
      chk("rr ptr after table", rr_dbg_ptr, 2'd1);

      // Consumer stall: word, tag and stb hold; new requests are not granted meanwhile.
      rr_data = 64'h0000_0000_1234_0000; rr_stb = 4'b0010; rr_z_ack = 1'b0;
      step(); chk("stall grant", rr_ack, 4'b0010);
      step(); chk("stall cap z_stb", rr_z_stb, 1'b1); chk("stall cap z", rr_z, 16'h1234);
      chk("stall cap id", rr_id, 2'd1);
      rr_stb = 4'hF; rr_data = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall z_stb", rr_z_stb, 1'b1); chk("stall z", rr_z, 16'h1234);
         chk("stall id", rr_id, 2'd1); chk("stall ack", rr_ack, 4'b0000);
      end
      rr_z_ack = 1'b1;
      step(); chk("stall release z_stb", rr_z_stb, 1'b0); chk("stall release ack", rr_ack, 4'b0000);
      chk("stall release state", rr_dbg_state, ST_IDLE);
      rr_stb = 4'b0000;
      step(); chk("stall idle ack", rr_ack, 4'b0000); chk("stall ptr", rr_dbg_ptr, 2'd2);

      // Reset while a captured word waits: word dropped, pointer back to channel 0.
      rr_data = 64'h0000_5555_0000_0000; rr_stb = 4'b0100; rr_z_ack = 1'b0;
      step(); chk("rst grant", rr_ack, 4'b0100);
      step(); chk("rst cap z_stb", rr_z_stb, 1'b1); chk("rst cap id", rr_id, 2'd2);
      rr_stb = 4'b0000; rst = 1'b1;
      step();
      chk("rst z_stb", rr_z_stb, 1'b0); chk("rst ack", rr_ack, 4'b0000);
      chk("rst z", rr_z, 16'h0000); chk("rst id", rr_id, 2'd0);
      chk("rst ptr", rr_dbg_ptr, 2'd0); chk("rst state", rr_dbg_state, ST_IDLE);
      rst = 1'b0; rr_data = 64'h3333_2222_1111_0A0A; rr_stb = 4'hF; rr_z_ack = 1'b1;
      step(); chk("post rst grant", rr_ack, 4'b0001);
      step(); chk("post rst z", rr_z, 16'h0A0A); chk("post rst id", rr_id, 2'd0);
      chk("post rst z_stb", rr_z_stb, 1'b1);
      rr_stb = 4'b0000;
      step(); chk("post rst done", rr_z_stb, 1'b0);

      // Pointer wrap: serving channel 3 returns the search to channel 0.
      rr_data = 64'h3333_0000_0000_0F0F; rr_stb = 4'b1000;
      step(); chk("wrap grant3", rr_ack, 4'b1000);
      step(); chk("wrap z3", rr_z, 16'h3333); chk("wrap id3", rr_id, 2'd3);
      rr_stb = 4'b1001;
      step(); chk("wrap out3", rr_z_stb, 1'b0); chk("wrap ptr", rr_dbg_ptr, 2'd0);
      step(); chk("wrap grant0", rr_ack, 4'b0001);
      step(); chk("wrap z0", rr_z, 16'h0F0F); chk("wrap id0", rr_id, 2'd0);
      chk("wrap z_stb0", rr_z_stb, 1'b1);
      step(); chk("wrap out0", rr_z_stb, 1'b0);
      step(); chk("wrap regrant3", rr_ack, 4'b1000);
      step(); chk("wrap reid3", rr_id, 2'd3);
      rr_stb = 4'b0000;
      step();

      // Fixed priority: channel 1 keeps winning over channel 3.
      fp_data = 64'hCCCC_0000_AAAA_0000; fp_stb = 4'b1010; fp_z_ack = 1'b1;
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         chk("fp ack3", fp_ack[3], 1'b0);
         if (fp_z_stb) begin
            chk("fp z", fp_z, 16'hAAAA);
            chk("fp id", fp_id, 2'd1);
            cnt++;
         end
      end
      chk("fp words", cnt, 3);
      fp_stb = 4'b0000;
      step();

      // Single channel: id and pointer pinned at 0, normal flow.
      one_data = 16'h7777; one_stb = 1'b1; one_z_ack = 1'b1;
      step(); chk("one grant", one_ack, 1'b1);
      step(); chk("one z", one_z, 16'h7777); chk("one id", one_id, 1'b0);
      chk("one z_stb", one_z_stb, 1'b1);
      step(); chk("one out", one_z_stb, 1'b0); chk("one ptr", one_dbg_ptr, 1'b0);
      step(); chk("one regrant", one_ack, 1'b1);
      step(); chk("one rez_stb", one_z_stb, 1'b1); chk("one reid", one_id, 1'b0);
      one_stb = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
